// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem request, IF/ID register, HLT handling
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        if_de_stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] ifid_insn,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_e;

  localparam logic [3:0]  OP_HLT   = 4'b1111;
  localparam logic [15:0] PC_EVEN  = 16'hFFFE;
  localparam logic [15:0] NOP_WORD = 16'h0000;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] ifid_insn_q;
  logic [15:0] ifid_pc_plus2_q;
  logic        ifid_valid_q;
  logic        halted_q;

  // PC+2 wraps naturally in 16 bits; the PC is always even so the sum stays even.
  logic [15:0] pc_plus2_d;
  logic        is_hlt_d;

  // Next sequential PC and HLT opcode decode of the returned word.
  always_comb begin
    pc_plus2_d = pc_q + 16'd2;
    is_hlt_d   = (imem_rdata[15:12] == OP_HLT);
  end

  // Fetch FSM and IF/ID register; conditions are checked in strict priority order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FETCH;
      pc_q            <= 16'h0000;
      ifid_insn_q     <= NOP_WORD;
      ifid_pc_plus2_q <= 16'h0000;
      ifid_valid_q    <= 1'b0;
      halted_q        <= 1'b0;
    end else if (branch_taken) begin
      // A redirect wins over stalls and over any wrong-path word (including HLT).
      state_q      <= FETCH;
      pc_q         <= branch_target & PC_EVEN;
      ifid_insn_q  <= NOP_WORD;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else if (pc_stall) begin
      // Hold everything; a word returned now is dropped and fetched again later.
      state_q         <= state_q;
      pc_q            <= pc_q;
      ifid_insn_q     <= ifid_insn_q;
      ifid_pc_plus2_q <= ifid_pc_plus2_q;
      ifid_valid_q    <= ifid_valid_q;
      halted_q        <= halted_q;
    end else if (if_de_stall) begin
      // Inject a bubble into decode while the PC waits.
      ifid_insn_q  <= NOP_WORD;
      ifid_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!imem_valid) begin
            // Miss: keep requesting the same address, feed a bubble meanwhile.
            ifid_insn_q  <= NOP_WORD;
            ifid_valid_q <= 1'b0;
          end else begin
            ifid_insn_q     <= imem_rdata;
            ifid_valid_q    <= 1'b1;
            ifid_pc_plus2_q <= pc_plus2_d;
            pc_q            <= pc_plus2_d;
            if (is_hlt_d) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end
          end
        end
        HALT: begin
          // Parked: only a branch or reset gets us out.
          ifid_insn_q  <= NOP_WORD;
          ifid_valid_q <= 1'b0;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  // Memory request is live only while fetching and out of reset.
  always_comb begin
    imem_req  = (state_q == FETCH) && !rst;
    imem_addr = pc_q;
  end

  assign ifid_insn     = ifid_insn_q;
  assign ifid_pc_plus2 = ifid_pc_plus2_q;
  assign ifid_valid    = ifid_valid_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed vectors
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_stall;
  logic        if_de_stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] ifid_insn;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_stall      (pc_stall),
    .if_de_stall   (if_de_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .ifid_insn     (ifid_insn),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] insn;
    logic [15:0] pp2;
    logic        valid;
    logic        hlt;
    logic        req;
    logic [15:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, "insn",  ifid_insn, e.insn);
        chk(e.name, "pp2",   ifid_pc_plus2, e.pp2);
        chk(e.name, "valid", {15'd0, ifid_valid}, {15'd0, e.valid});
        chk(e.name, "halted", {15'd0, halted}, {15'd0, e.hlt});
        chk(e.name, "req",   {15'd0, imem_req}, {15'd0, e.req});
        chk(e.name, "addr",  imem_addr, e.addr);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string nm,
                      input logic r, input logic ps, input logic ids,
                      input logic bt, input logic [15:0] tgt,
                      input logic iv, input logic [15:0] rd,
                      input logic [15:0] e_insn, input logic [15:0] e_pp2,
                      input logic e_v, input logic e_h, input logic e_req,
                      input logic [15:0] e_addr);
    exp_t e;
    @(negedge clk);
    rst           = r;
    pc_stall      = ps;
    if_de_stall   = ids;
    branch_taken  = bt;
    branch_target = tgt;
    imem_valid    = iv;
    imem_rdata    = rd;
    e.name  = nm;
    e.insn  = e_insn;
    e.pp2   = e_pp2;
    e.valid = e_v;
    e.hlt   = e_h;
    e.req   = e_req;
    e.addr  = e_addr;
    sb_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; pc_stall = 1'b0; if_de_stall = 1'b0; branch_taken = 1'b0;
    branch_target = 16'h0; imem_valid = 1'b0; imem_rdata = 16'h0;

    //    name        rst ps ids bt tgt       iv rdata     insn      pp2      v  h  req addr
    step("reset0",    1, 0, 0, 0, 16'h0000, 1, 16'h1111, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
    step("reset1",    1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
    step("first_req", 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000);
    // straight line
    step("line1",     0, 0, 0, 0, 16'h0000, 1, 16'h1111, 16'h1111, 16'h0002, 1, 0, 1, 16'h0002);
    step("line2",     0, 0, 0, 0, 16'h0000, 1, 16'h2222, 16'h2222, 16'h0004, 1, 0, 1, 16'h0004);
    step("line3",     0, 0, 0, 0, 16'h0000, 1, 16'h3333, 16'h3333, 16'h0006, 1, 0, 1, 16'h0006);
    step("line4",     0, 0, 0, 0, 16'h0000, 1, 16'h4444, 16'h4444, 16'h0008, 1, 0, 1, 16'h0008);
    // miss at 0x0004
    step("rst_b",     1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
    step("hitA",      0, 0, 0, 0, 16'h0000, 1, 16'hAAAA, 16'hAAAA, 16'h0002, 1, 0, 1, 16'h0002);
    step("hitB",      0, 0, 0, 0, 16'h0000, 1, 16'hBBBB, 16'hBBBB, 16'h0004, 1, 0, 1, 16'h0004);
    step("miss1",     0, 0, 0, 0, 16'h0000, 0, 16'h5A5A, 16'h0000, 16'h0004, 0, 0, 1, 16'h0004);
    step("miss2",     0, 0, 0, 0, 16'h0000, 0, 16'h5A5A, 16'h0000, 16'h0004, 0, 0, 1, 16'h0004);
    step("miss3",     0, 0, 0, 0, 16'h0000, 0, 16'h5A5A, 16'h0000, 16'h0004, 0, 0, 1, 16'h0004);
    step("hitC",      0, 0, 0, 0, 16'h0000, 1, 16'hCCCC, 16'hCCCC, 16'h0006, 1, 0, 1, 16'h0006);
    // stall and flush
    step("stall1",    0, 1, 1, 0, 16'h0000, 1, 16'hDDDD, 16'hCCCC, 16'h0006, 1, 0, 1, 16'h0006);
    step("stall2",    0, 1, 1, 0, 16'h0000, 1, 16'hDDDD, 16'hCCCC, 16'h0006, 1, 0, 1, 16'h0006);
    step("flush",     0, 0, 1, 0, 16'h0000, 1, 16'hDDDD, 16'h0000, 16'h0006, 0, 0, 1, 16'h0006);
    step("hitD",      0, 0, 0, 0, 16'h0000, 1, 16'hDDDD, 16'hDDDD, 16'h0008, 1, 0, 1, 16'h0008);
    // branch beats pc_stall and a wrong-path HLT
    step("br_prio",   0, 1, 0, 1, 16'h0100, 1, 16'hF000, 16'h0000, 16'h0008, 0, 0, 1, 16'h0100);
    step("hit100",    0, 0, 0, 0, 16'h0000, 1, 16'h5555, 16'h5555, 16'h0102, 1, 0, 1, 16'h0102);
    step("br_odd",    0, 0, 0, 1, 16'h0011, 0, 16'h0000, 16'h0000, 16'h0102, 0, 0, 1, 16'h0010);
    // halt and resume
    step("hlt",       0, 0, 0, 0, 16'h0000, 1, 16'hF000, 16'hF000, 16'h0012, 1, 1, 0, 16'h0012);
    step("halt1",     0, 0, 0, 0, 16'h0000, 1, 16'h1111, 16'h0000, 16'h0012, 0, 1, 0, 16'h0012);
    step("halt2",     0, 0, 0, 0, 16'h0000, 1, 16'h1111, 16'h0000, 16'h0012, 0, 1, 0, 16'h0012);
    step("resume",    0, 0, 0, 1, 16'h0020, 0, 16'h0000, 16'h0000, 16'h0012, 0, 0, 1, 16'h0020);
    step("hit20",     0, 0, 0, 0, 16'h0000, 1, 16'h6666, 16'h6666, 16'h0022, 1, 0, 1, 16'h0022);
    // PC wrap
    step("br_fffe",   0, 0, 0, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 16'h0022, 0, 0, 1, 16'hFFFE);
    step("wrap",      0, 0, 0, 0, 16'h0000, 1, 16'h7777, 16'h7777, 16'h0000, 1, 0, 1, 16'h0000);
    // reset out of HALT, with stall and branch also asserted
    step("br_30",     0, 0, 0, 1, 16'h0030, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 16'h0030);
    step("hlt30",     0, 0, 0, 0, 16'h0000, 1, 16'hF123, 16'hF123, 16'h0032, 1, 1, 0, 16'h0032);
    step("rst_halt",  1, 1, 1, 1, 16'h0040, 1, 16'h1111, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
    step("post_rst",  0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain remaining=%0d expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL expose `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL expose `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL expose `pc_stall`, input, 1 bit: hold the PC and the IF/ID register this cycle; from hazard detection.
REQ-004 SHALL expose `if_de_stall`, input, 1 bit: when `pc_stall`=0, load NOP into IF/ID; when `pc_stall`=1, hold; from hazard detection.
REQ-005 SHALL expose `branch_taken`, input, 1 bit: a resolved branch redirects fetch this cycle.
REQ-006 SHALL expose `branch_target`, input, 16 bits: redirect address, valid when `branch_taken`=1.
REQ-007 SHALL expose `imem_req`, output, 1 bit: instruction memory read request.
REQ-008 SHALL expose `imem_addr`, output, 16 bits: byte address of the requested instruction; equals the current PC.
REQ-009 SHALL expose `imem_rdata`, input, 16 bits: instruction word, meaningful when `imem_valid`=1.
REQ-010 SHALL expose `imem_valid`, input, 1 bit: `imem_rdata` holds the word at `imem_addr` this cycle (hit). May be 0 for any number of cycles (miss).
REQ-011 SHALL expose `ifid_insn`, output, 16 bits: registered instruction to decode.
REQ-012 SHALL expose `ifid_pc_plus2`, output, 16 bits: registered PC+2 of `ifid_insn`.
REQ-013 SHALL expose `ifid_valid`, output, 1 bit: 1 = real instruction, 0 = bubble.
REQ-014 SHALL expose `halted`, output, 1 bit: registered; 1 once HLT has been fetched and fetch has stopped.

Function
REQ-015 SHALL implement FSM states FETCH and HALT.
REQ-016 SHALL encode NOP/bubble as `ifid_insn`=16'h0000, `ifid_valid`=0, `ifid_pc_plus2` unchanged.
REQ-017 SHALL drive `imem_req`=1 in FETCH and 0 in HALT and during reset; `imem_addr`=PC combinationally.
REQ-018 SHALL, on each edge, apply the first matching condition in this order: `rst`, `branch_taken`, `pc_stall`, `if_de_stall`, then the state action.
REQ-019 SHALL, on `branch_taken`=1 in any state: PC<=`branch_target`; IF/ID<=NOP; state<=FETCH; `halted`<=0. This overrides `pc_stall` and wrong-path HLT.
REQ-020 SHALL, on `pc_stall`=1 (no branch): hold PC, IF/ID and state. Any word returned this cycle is discarded and refetched.
REQ-021 SHALL, on `if_de_stall`=1 with `pc_stall`=0 (no branch): IF/ID<=NOP; hold PC and state; discard any returned word.
REQ-022 SHALL, in FETCH with `imem_valid`=0: IF/ID<=NOP; hold PC; keep `imem_req` high and `imem_addr` stable until the hit.
REQ-023 SHALL, in FETCH with `imem_valid`=1 and `imem_rdata[15:12]`!=4'b1111: `ifid_insn`<=rdata; `ifid_valid`<=1; `ifid_pc_plus2`<=PC+2; PC<=PC+2.
REQ-024 SHALL, in FETCH with `imem_valid`=1 and opcode 4'b1111 (HLT): load HLT into IF/ID (valid=1, pc_plus2=PC+2); PC<=PC+2; state<=HALT; `halted`<=1.
REQ-025 SHALL, in HALT without `branch_taken`: IF/ID<=NOP every cycle; hold PC; leave HALT only via `branch_taken` or `rst`.
REQ-026 SHALL compute PC+2 modulo 2^16 (16'hFFFE+2 = 16'h0000); PC bit 0 SHALL be forced to 0 on load.
REQ-027 SHALL have fetch latency of one edge: a hit at cycle N appears on `ifid_*` after edge N; back-to-back hits yield one instruction per cycle.

Reset
REQ-028 SHALL, when `rst`=1 at an edge: PC<=16'h0000; state<=FETCH; `ifid_insn`<=16'h0000; `ifid_valid`<=0; `ifid_pc_plus2`<=16'h0000; `halted`<=0. This applies regardless of state, stall or branch.
REQ-029 SHALL drive `imem_req`=0 while `rst`=1, and issue the first request to address 0x0000 in the first cycle after reset.

Verification
REQ-030 Straight line: rst, then `imem_valid`=1 for 4 cycles returning 0x1111/0x2222/0x3333/0x4444 -> `ifid_insn` shows that sequence with `ifid_pc_plus2`=2,4,6,8; `ifid_valid`=1.
REQ-031 Miss: `imem_valid`=0 for 3 cycles at PC=0x0004 -> `imem_addr` stays 0x0004 and 3 bubbles are produced; on the hit `ifid_pc_plus2`=0x0006.
REQ-032 Stall/flush: `pc_stall`=`if_de_stall`=1 for 2 cycles -> PC and `ifid_*` unchanged. Then `if_de_stall` alone for 1 cycle -> `ifid_valid`=0 and PC unchanged.
REQ-033 Branch priority: `branch_taken`=1, `branch_target`=0x0100, `pc_stall`=1 at the same edge -> PC=0x0100 and IF/ID=NOP on the next cycle.
REQ-034 Halt: HLT (0xF000) fetched at 0x0010 -> IF/ID holds 0xF000, `halted`=1, `imem_req`=0, and bubbles follow. Then `branch_taken` to 0x0020 -> `halted`=0 and fetch resumes at 0x0020.
REQ-035 Wrap/reset: PC=0xFFFE with a hit -> PC=0x0000. Asserting `rst` in HALT -> all outputs return to REQ-028 values at the next edge.
